tage_folded_history: RTL and testbench
======================================

TAGE_FOLDED_HISTORY -- requirements
Module: tage_folded_history

Interface
REQ-001 Parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, full derived config; uses nTagHistoryTables, histLengths, tagTableTagWidths, tagTableSizes, histBufferBits, pathHistBits.
REQ-002 Parameter type ghist_ckpt_t, default logic, checkpoint struct {ptr, idx_fold[N], tag0_fold[N], tag1_fold[N], path}.
REQ-003 clk_i  in  1  core clock, all state on rising edge.
REQ-004 rst_ni  in  1  asynchronous active-low reset.
REQ-005 push_valid_i  in  1  one resolved/predicted branch outcome enters history this cycle.
REQ-006 push_taken_i  in  1  direction bit to insert.
REQ-007 push_pc_bit_i  in  1  PC bit to insert into path history.
REQ-008 restore_valid_i  in  1  rewind to restore_ckpt_i (mispredict recovery).
REQ-009 restore_ckpt_i  in  ghist_ckpt_t  state to rewind to.
REQ-010 ckpt_o  out  ghist_ckpt_t  current registered state, captured by frontend per prediction.
REQ-011 idx_fold_o[N]  out  IdxW(i)=$clog2(tagTableSizes[i])  folded history for table i index hash.
REQ-012 tag0_fold_o[N] / tag1_fold_o[N]  out  TagW(i) / TagW(i)-1  folded histories for tag hash.
REQ-013 path_hist_o  out  pathHistBits  path history register.

Function
REQ-014 History buffer: B=histBufferBits bits, circular, pointer ptr ($clog2(B) bits); age-k bit h[k]=buf[(ptr+k) mod B], k=0 newest.
REQ-015 Push: ptr'=(ptr-1) mod B (0 wraps to B-1); buf[ptr'] = push_taken_i; path'={path[P-2:0], push_pc_bit_i}.
REQ-016 Fold update per register (width W, table length L=histLengths[i]), outgoing o=old h[L-1]: t=rotl1(fold); t[0]^=b; t[L mod W]^=o; fold'=t.
REQ-017 When L mod W == 0, b and o both XOR into bit 0 (cancel if equal).
REQ-018 No push: all state holds.
REQ-019 Restore: ptr, all folds, path load from restore_ckpt_i; buffer contents untouched.
REQ-020 Restore and push same cycle: push applied on restored state; o read at restored ptr; result registered in one cycle.
REQ-021 Latency: outputs and ckpt_o are registered; a push in cycle n is visible in cycle n+1.
REQ-022 ckpt_o and fold outputs reflect identical state every cycle.
REQ-023 Elaboration assertion: B > max(histLengths) + in-flight checkpoint depth; TagW(i) >= 2; IdxW(i) >= 1.

Reset
REQ-024 Asynchronous on rst_ni low: ptr=0, buf=0, all folds=0, path=0; all outputs 0 during reset.
REQ-025 Reset mid-operation drops pending push/restore; first push after deassert uses zeroed state.

Structure
REQ-026 New fields FoldIdxMaxW and FoldTagMaxW computed in build_config_pkg; ghist_ckpt_t declared in cva6 top with other cfg-derived types and passed down.
REQ-027 One sub-module tage_fold_reg (params W, L; ports clk_i, rst_ni, push, b, o, restore, restore value, fold_o), instantiated 3N times.

Verification
REQ-028 Reset, push taken=1 once -> ptr=B-1, each fold=1, path=1 next cycle.
REQ-029 W=8, L=12: push 12 ones then one zero -> fold equals bit-exact software model (outgoing one XORs bit 4).
REQ-030 Push B+3 bits -> ptr wraps 0 -> B-1; h[k] matches model for k<B.
REQ-031 Capture ckpt_o, push 20 random bits, restore -> outputs equal captured values next cycle.
REQ-032 Restore plus push taken=1 same cycle -> state equals captured ckpt advanced by one taken push.
REQ-033 L=W=8: push 8 ones, then a one -> bit 0 unchanged by b^o cancel, matches model.

Source files
------------

// File: rtl/tage_folded_history_pkg.sv
// Configuration, derived widths and checkpoint type shared by the TAGE folded history block.
// Pure declarations, so there is no latency or backpressure to describe.
package tage_folded_history_pkg;

  localparam int NTagTables      = 3;
  localparam int HistBufferBits  = 64;
  localparam int PathHistBits    = 16;
  localparam int MaxInflightCkpt = 16;

  // Element 0 is table 0 (shortest history).
  localparam logic [NTagTables-1:0][31:0] HistLengths       = {32'd32, 32'd12, 32'd8};
  localparam logic [NTagTables-1:0][31:0] TagTableTagWidths = {32'd9, 32'd8, 32'd8};
  localparam logic [NTagTables-1:0][31:0] TagTableSizes     = {32'd512, 32'd256, 32'd256};

  localparam int PtrW = $clog2(HistBufferBits);

  function automatic int hist_len(input int i);
    return int'(HistLengths[i]);
  endfunction

  function automatic int idx_w(input int i);
    return $clog2(TagTableSizes[i]);
  endfunction

  function automatic int tag_w(input int i);
    return int'(TagTableTagWidths[i]);
  endfunction

  function automatic int max_hist_len();
    int m;
    m = 0;
    for (int i = 0; i < NTagTables; i++) if (hist_len(i) > m) m = hist_len(i);
    return m;
  endfunction

  function automatic int fold_idx_max_w();
    int m;
    m = 1;
    for (int i = 0; i < NTagTables; i++) if (idx_w(i) > m) m = idx_w(i);
    return m;
  endfunction

  function automatic int fold_tag_max_w();
    int m;
    m = 1;
    for (int i = 0; i < NTagTables; i++) if (tag_w(i) > m) m = tag_w(i);
    return m;
  endfunction

  localparam int FoldIdxMaxW = fold_idx_max_w();
  localparam int FoldTagMaxW = fold_tag_max_w();

  // Folds narrower than the max width sit in the low bits, upper bits zero.
  typedef struct packed {
    logic [PtrW-1:0]                        ptr;
    logic [NTagTables-1:0][FoldIdxMaxW-1:0] idx_fold;
    logic [NTagTables-1:0][FoldTagMaxW-1:0] tag0_fold;
    logic [NTagTables-1:0][FoldTagMaxW-1:0] tag1_fold;
    logic [PathHistBits-1:0]                path;
  } ghist_ckpt_t;

  // Buffer position of the age-k history bit for a given head pointer.
  function automatic logic [PtrW-1:0] age_idx(input logic [PtrW-1:0] p, input int k);
    return PtrW'((32'(p) + 32'(k)) % 32'(HistBufferBits));
  endfunction

endpackage

// File: rtl/tage_fold_reg.sv
// One folded-history register: rotate left, insert newest bit at 0, cancel outgoing bit at L mod W.
// Registered, one-cycle update; restore and push in the same cycle fold onto the restored value; no backpressure.
module tage_fold_reg #(
  parameter int W = 8,
  parameter int L = 12
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         b_i,
  input  logic         o_i,
  input  logic         restore_i,
  input  logic [W-1:0] restore_val_i,
  output logic [W-1:0] fold_o
);

  localparam int OutPos = L % W;

  logic [W-1:0] base, rot, nxt;

  always_comb begin
    base = restore_i ? restore_val_i : fold_o;
    rot  = '0;
    for (int k = 0; k < W; k++) rot[(k + 1) % W] = base[k];
    nxt         = rot;
    nxt[0]      = nxt[0] ^ b_i;
    nxt[OutPos] = nxt[OutPos] ^ o_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        fold_o <= '0;
    else if (push_i)    fold_o <= nxt;
    else if (restore_i) fold_o <= restore_val_i;
  end

endmodule

// File: rtl/tage_folded_history.sv
// TAGE global history: circular direction buffer, path history and index/tag folds per table.
// Push or restore in cycle n is visible on all outputs in cycle n+1; always accepts, no backpressure.
module tage_folded_history
  import tage_folded_history_pkg::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  push_valid_i,
  input  logic                                  push_taken_i,
  input  logic                                  push_pc_bit_i,
  input  logic                                  restore_valid_i,
  input  ghist_ckpt_t                           restore_ckpt_i,
  output ghist_ckpt_t                           ckpt_o,
  output logic [NTagTables-1:0][FoldIdxMaxW-1:0] idx_fold_o,
  output logic [NTagTables-1:0][FoldTagMaxW-1:0] tag0_fold_o,
  output logic [NTagTables-1:0][FoldTagMaxW-1:0] tag1_fold_o,
  output logic [PathHistBits-1:0]               path_hist_o
);

  logic [HistBufferBits-1:0] buf_q;
  logic [PtrW-1:0]           ptr_q, ptr_base, ptr_d;
  logic [PathHistBits-1:0]   path_q, path_base, path_d;
  logic                      unused_ckpt_bits;

  if (HistBufferBits <= max_hist_len() + MaxInflightCkpt) begin : g_err_buf
    $error("history buffer too short for longest history plus in-flight checkpoints");
  end

  // Push always operates on the restored state when both arrive together.
  always_comb begin
    ptr_base  = restore_valid_i ? restore_ckpt_i.ptr  : ptr_q;
    path_base = restore_valid_i ? restore_ckpt_i.path : path_q;
    ptr_d     = ptr_base;
    path_d    = path_base;
    if (push_valid_i) begin
      ptr_d  = (ptr_base == '0) ? PtrW'(HistBufferBits - 1) : ptr_base - PtrW'(1);
      path_d = {path_base[PathHistBits-2:0], push_pc_bit_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      path_q <= '0;
      buf_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      path_q <= path_d;
      if (push_valid_i) buf_q[ptr_d] <= push_taken_i;
    end
  end

  for (genvar i = 0; i < NTagTables; i++) begin : g_tbl
    localparam int L   = hist_len(i);
    localparam int IW  = idx_w(i);
    localparam int TW  = tag_w(i);
    localparam int T1W = TW - 1;

    if (TW < 2 || IW < 1) begin : g_err_w
      $error("fold widths too small for a tagged table");
    end

    logic           o_bit;
    logic [IW-1:0]  idx_q;
    logic [TW-1:0]  tag0_q;
    logic [T1W-1:0] tag1_q;

    // Bit leaving this table's window: old age L-1, read before the buffer write lands.
    assign o_bit = buf_q[age_idx(ptr_base, L - 1)];

    tage_fold_reg #(.W(IW), .L(L)) u_idx (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_valid_i), .b_i(push_taken_i), .o_i(o_bit),
      .restore_i(restore_valid_i), .restore_val_i(restore_ckpt_i.idx_fold[i][IW-1:0]), .fold_o(idx_q)
    );
    tage_fold_reg #(.W(TW), .L(L)) u_tag0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_valid_i), .b_i(push_taken_i), .o_i(o_bit),
      .restore_i(restore_valid_i), .restore_val_i(restore_ckpt_i.tag0_fold[i][TW-1:0]), .fold_o(tag0_q)
    );
    tage_fold_reg #(.W(T1W), .L(L)) u_tag1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .push_i(push_valid_i), .b_i(push_taken_i), .o_i(o_bit),
      .restore_i(restore_valid_i), .restore_val_i(restore_ckpt_i.tag1_fold[i][T1W-1:0]), .fold_o(tag1_q)
    );

    assign idx_fold_o[i]  = FoldIdxMaxW'(idx_q);
    assign tag0_fold_o[i] = FoldTagMaxW'(tag0_q);
    assign tag1_fold_o[i] = FoldTagMaxW'(tag1_q);
  end

  assign path_hist_o = path_q;
  assign ckpt_o      = {ptr_q, idx_fold_o, tag0_fold_o, tag1_fold_o, path_q};

  // Padding above each fold width in a checkpoint is don't-care.
  assign unused_ckpt_bits = ^restore_ckpt_i;

endmodule

// File: tb/tb_tage_folded_history.sv
// Bench: directed vector table, wrap/restore/reset sequences, scoreboard against a closed-form fold model.
module tb_tage_folded_history;
  import tage_folded_history_pkg::*;

  localparam int B = HistBufferBits;
  localparam int P = PathHistBits;

  logic clk_i = 1'b0;
  logic rst_ni, push_valid_i, push_taken_i, push_pc_bit_i, restore_valid_i;
  ghist_ckpt_t restore_ckpt_i, ckpt_o;
  logic [NTagTables-1:0][FoldIdxMaxW-1:0] idx_fold_o;
  logic [NTagTables-1:0][FoldTagMaxW-1:0] tag0_fold_o, tag1_fold_o;
  logic [P-1:0] path_hist_o;

  always #5 clk_i = ~clk_i;

  tage_folded_history dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_valid_i(push_valid_i), .push_taken_i(push_taken_i),
    .push_pc_bit_i(push_pc_bit_i), .restore_valid_i(restore_valid_i), .restore_ckpt_i(restore_ckpt_i),
    .ckpt_o(ckpt_o), .idx_fold_o(idx_fold_o), .tag0_fold_o(tag0_fold_o), .tag1_fold_o(tag1_fold_o),
    .path_hist_o(path_hist_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [B-1:0] mbuf;
  int           mptr;
  logic [P-1:0] mpath;
  ghist_ckpt_t  exp_q[$];

  typedef struct {
    logic            push;
    logic            taken;
    logic            pc;
    logic [PtrW-1:0] ptr;
    logic [7:0]      idx0;
    logic [7:0]      idx1;
    logic [P-1:0]    path;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Fold bit j is the XOR of every history bit of age k < L with k mod W == j.
  function automatic ghist_ckpt_t model_ckpt();
    ghist_ckpt_t c;
    c      = '0;
    c.ptr  = PtrW'(mptr);
    c.path = mpath;
    for (int i = 0; i < NTagTables; i++) begin
      for (int k = 0; k < hist_len(i); k++) begin
        logic h;
        h = mbuf[(mptr + k) % B];
        c.idx_fold[i][k % idx_w(i)]        ^= h;
        c.tag0_fold[i][k % tag_w(i)]       ^= h;
        c.tag1_fold[i][k % (tag_w(i) - 1)] ^= h;
      end
    end
    return c;
  endfunction

  task automatic model_reset();
    mbuf  = '0;
    mptr  = 0;
    mpath = '0;
    exp_q.delete();
  endtask

  task automatic step(input logic push, input logic taken, input logic pc, input logic restore,
                      input ghist_ckpt_t ck, input string tag);
    ghist_ckpt_t e, got;
    @(negedge clk_i);
    push_valid_i    = push;
    push_taken_i    = taken;
    push_pc_bit_i   = pc;
    restore_valid_i = restore;
    restore_ckpt_i  = ck;
    if (restore) begin
      mptr  = int'(ck.ptr);
      mpath = ck.path;
    end
    if (push) begin
      mptr       = (mptr + B - 1) % B;
      mbuf[mptr] = taken;
      mpath      = {mpath[P-2:0], pc};
    end
    exp_q.push_back(model_ckpt());
    @(posedge clk_i);
    #1;
    push_valid_i    = 1'b0;
    restore_valid_i = 1'b0;
    e   = exp_q.pop_front();
    got = {ckpt_o.ptr, idx_fold_o, tag0_fold_o, tag1_fold_o, path_hist_o};
    check({tag, " ckpt"}, 128'(ckpt_o), 128'(e));
    check({tag, " outs"}, 128'(got), 128'(e));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni          = 1'b0;
    push_valid_i    = 1'b0;
    restore_valid_i = 1'b0;
    model_reset();
    #1;
    check("reset ckpt", 128'(ckpt_o), 128'(0));
    check("reset folds", 128'({idx_fold_o, tag0_fold_o, tag1_fold_o, path_hist_o}), 128'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic setv(input int r, input logic push, input logic taken, input logic pc, input int ptr,
                      input logic [7:0] i0, input logic [7:0] i1, input logic [P-1:0] path);
    vecs[r] = '{push, taken, pc, PtrW'(ptr), i0, i1, path};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ghist_ckpt_t cap;
    logic [NTagTables-1:0][FoldIdxMaxW-1:0] ones_idx;
    logic [NTagTables-1:0][FoldTagMaxW-1:0] ones_tag;
    logic [PtrW-1:0] ptr_exp;

    rst_ni = 1'b0; push_valid_i = 1'b0; push_taken_i = 1'b0; push_pc_bit_i = 1'b0;
    restore_valid_i = 1'b0; restore_ckpt_i = '0;
    for (int i = 0; i < NTagTables; i++) begin
      ones_idx[i] = FoldIdxMaxW'(1);
      ones_tag[i] = FoldTagMaxW'(1);
    end

    // Table 0 is L=W=8, table 1 is L=12 W=8.
    setv(0,  1'b1, 1'b1, 1'b1, 63, 8'h01, 8'h01, 16'h0001);
    setv(1,  1'b1, 1'b1, 1'b1, 62, 8'h03, 8'h03, 16'h0003);
    setv(2,  1'b1, 1'b1, 1'b1, 61, 8'h07, 8'h07, 16'h0007);
    setv(3,  1'b1, 1'b1, 1'b1, 60, 8'h0F, 8'h0F, 16'h000F);
    setv(4,  1'b1, 1'b1, 1'b1, 59, 8'h1F, 8'h1F, 16'h001F);
    setv(5,  1'b1, 1'b1, 1'b1, 58, 8'h3F, 8'h3F, 16'h003F);
    setv(6,  1'b1, 1'b1, 1'b1, 57, 8'h7F, 8'h7F, 16'h007F);
    setv(7,  1'b1, 1'b1, 1'b1, 56, 8'hFF, 8'hFF, 16'h00FF);
    setv(8,  1'b0, 1'b0, 1'b0, 56, 8'hFF, 8'hFF, 16'h00FF);
    setv(9,  1'b1, 1'b1, 1'b1, 55, 8'hFF, 8'hFE, 16'h01FF);
    setv(10, 1'b1, 1'b1, 1'b1, 54, 8'hFF, 8'hFC, 16'h03FF);
    setv(11, 1'b1, 1'b1, 1'b1, 53, 8'hFF, 8'hF8, 16'h07FF);
    setv(12, 1'b1, 1'b1, 1'b1, 52, 8'hFF, 8'hF0, 16'h0FFF);
    setv(13, 1'b1, 1'b0, 1'b0, 51, 8'hFE, 8'hF1, 16'h1FFE);

    do_reset();
    for (int r = 0; r < 14; r++) begin
      step(vecs[r].push, vecs[r].taken, vecs[r].pc, 1'b0, '0, $sformatf("vec%0d", r));
      check($sformatf("vec%0d ptr", r),  128'(ckpt_o.ptr),    128'(vecs[r].ptr));
      check($sformatf("vec%0d idx0", r), 128'(idx_fold_o[0]), 128'(vecs[r].idx0));
      check($sformatf("vec%0d idx1", r), 128'(idx_fold_o[1]), 128'(vecs[r].idx1));
      check($sformatf("vec%0d path", r), 128'(path_hist_o),   128'(vecs[r].path));
      if (r == 0) begin
        check("first push idx folds", 128'(idx_fold_o), 128'(ones_idx));
        check("first push tag0 folds", 128'(tag0_fold_o), 128'(ones_tag));
        check("first push tag1 folds", 128'(tag1_fold_o), 128'(ones_tag));
      end
    end

    // Pointer wrap over more than one full buffer.
    do_reset();
    for (int n = 1; n <= B + 3; n++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, "wrap");
      if (n == B)     check("wrap ptr at B", 128'(ckpt_o.ptr), 128'(0));
      if (n == B + 1) check("wrap ptr at B+1", 128'(ckpt_o.ptr), 128'(B - 1));
    end
    check("wrap buffer contents", 128'(dut.buf_q), 128'(mbuf));

    // Checkpoint, run ahead, rewind.
    cap = model_ckpt();
    check("capture ckpt", 128'(ckpt_o), 128'(cap));
    for (int n = 0; n < 20; n++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, "runahead");
    step(1'b0, 1'b0, 1'b0, 1'b1, cap, "restore");
    check("restore equals capture", 128'(ckpt_o), 128'(cap));

    // Rewind and push taken in the same cycle.
    for (int n = 0; n < 5; n++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, "runahead2");
    step(1'b1, 1'b1, 1'b1, 1'b1, cap, "restore+push");
    ptr_exp = (cap.ptr == '0) ? PtrW'(B - 1) : cap.ptr - PtrW'(1);
    check("restore+push ptr", 128'(ckpt_o.ptr), 128'(ptr_exp));
    check("restore+push path", 128'(path_hist_o), 128'({cap.path[P-2:0], 1'b1}));

    // Reset arriving with a push and restore pending.
    @(negedge clk_i);
    push_valid_i = 1'b1; push_taken_i = 1'b1; push_pc_bit_i = 1'b1;
    restore_valid_i = 1'b1; restore_ckpt_i = cap;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("mid reset ckpt", 128'(ckpt_o), 128'(0));
    check("mid reset path", 128'(path_hist_o), 128'(0));
    @(negedge clk_i);
    push_valid_i = 1'b0; restore_valid_i = 1'b0; rst_ni = 1'b1;
    model_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, "post-reset push");
    check("post-reset ptr", 128'(ckpt_o.ptr), 128'(B - 1));
    check("post-reset idx folds", 128'(idx_fold_o), 128'(ones_idx));
    check("post-reset path", 128'(path_hist_o), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
